// File: rtl/cond_logic_it_if.sv
// rtl/cond_logic_it_if.sv - decode-side bundle between the core and the conditional-execution unit
// The core drives decode fields and reads the gated write enables back.
interface cond_logic_it_if #(
   parameter int NUM_BANKS = 2,
   parameter int IT_DEPTH  = 4
);
   localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int LW = $clog2(IT_DEPTH + 1);

   logic                InstrValid;
   logic                PCS;
   logic                RegW;
   logic                MemW;
   logic [1:0]          FlagW;
   logic [3:0]          Cond;
   logic [3:0]          ALUFlags;
   logic [BW-1:0]       BankSel;
   logic                ITStart;
   logic [3:0]          ITCond;
   logic [IT_DEPTH-1:0] ITMask;
   logic [LW-1:0]       ITLen;
   logic                Flush;

   logic                PCSrc;
   logic                RegWrite;
   logic                MemWrite;
   logic                CondEx;
   logic [3:0]          FlagsOut;
   logic                InIT;
   logic [LW-1:0]       ITRemain;
   logic                ITErr;

   modport master (
      output InstrValid, PCS, RegW, MemW, FlagW, Cond, ALUFlags, BankSel,
             ITStart, ITCond, ITMask, ITLen, Flush,
      input  PCSrc, RegWrite, MemWrite, CondEx, FlagsOut, InIT, ITRemain, ITErr
   );

   modport slave (
      input  InstrValid, PCS, RegW, MemW, FlagW, Cond, ALUFlags, BankSel,
             ITStart, ITCond, ITMask, ITLen, Flush,
      output PCSrc, RegWrite, MemWrite, CondEx, FlagsOut, InIT, ITRemain, ITErr
   );
endinterface

// File: rtl/cond_logic_it.sv
// rtl/cond_logic_it.sv - banked NZCV flags, ARM condition evaluation and IT block sequencer
// Conditions resolve combinationally from registered flags; only state updates are clocked.
module cond_logic_it #(
   parameter int NUM_BANKS = 2,
   parameter int IT_DEPTH  = 4
) (
   input  logic           CLK,
   input  logic           RESETn,
   cond_logic_it_if.slave bus
);
   localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int LW = $clog2(IT_DEPTH + 1);

   logic [3:0]          flags_q [NUM_BANKS];
   logic [3:0]          flags_d [NUM_BANKS];
   logic                in_it_q, in_it_d;
   logic [LW-1:0]       it_remain_q, it_remain_d;
   logic [IT_DEPTH-1:0] mask_q, mask_d;
   logic [3:0]          it_cond_q, it_cond_d;
   logic                it_err_q, it_err_d;

   logic [3:0]          cur_flags;
   logic [3:0]          eff_cond;
   logic                cond_true;
   logic                cond_ex;
   logic                gate;
   logic [IT_DEPTH-1:0] len_mask;
   logic                len_ok;
   logic                it_ok;
   logic                it_try;
   logic                it_accept;
   logic                flag_n, flag_z, flag_c, flag_v;

   // Banks beyond NUM_BANKS (non power-of-two counts) read as zero.
   always_comb begin
      cur_flags = 4'b0000;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (bus.BankSel == BW'(b)) cur_flags = flags_q[b];
      end
   end

   assign {flag_n, flag_z, flag_c, flag_v} = cur_flags;

   always_comb begin
      if (!in_it_q)      eff_cond = bus.Cond;
      else if (mask_q[0]) eff_cond = it_cond_q;
      else               eff_cond = {it_cond_q[3:1], ~it_cond_q[0]};
   end

   always_comb begin
      case (eff_cond)
         4'b0000: cond_true = flag_z;
         4'b0001: cond_true = ~flag_z;
         4'b0010: cond_true = flag_c;
         4'b0011: cond_true = ~flag_c;
         4'b0100: cond_true = flag_n;
         4'b0101: cond_true = ~flag_n;
         4'b0110: cond_true = flag_v;
         4'b0111: cond_true = ~flag_v;
         4'b1000: cond_true = flag_c & ~flag_z;
         4'b1001: cond_true = ~flag_c | flag_z;
         4'b1010: cond_true = (flag_n == flag_v);
         4'b1011: cond_true = (flag_n != flag_v);
         4'b1100: cond_true = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_true = flag_z | (flag_n != flag_v);
         default: cond_true = 1'b1;
      endcase
   end

   // An IT opening a block always executes; one arriving inside a block takes its slot condition.
   assign cond_ex = (bus.ITStart & ~in_it_q) | cond_true;
   assign gate    = bus.InstrValid & cond_ex & ~bus.ITStart;

   assign bus.CondEx   = cond_ex;
   assign bus.PCSrc    = bus.PCS  & gate;
   assign bus.RegWrite = bus.RegW & gate;
   assign bus.MemWrite = bus.MemW & gate;
   assign bus.FlagsOut = cur_flags;
   assign bus.InIT     = in_it_q;
   assign bus.ITRemain = it_remain_q;
   assign bus.ITErr    = it_err_q;

   always_comb begin
      len_mask = '0;
      for (int i = 0; i < IT_DEPTH; i++) begin
         if (i < int'(bus.ITLen)) len_mask[i] = 1'b1;
      end
   end

   // AL has no inverse, so an Else slot under an AL base is malformed.
   assign len_ok    = (bus.ITLen != '0) && (int'(bus.ITLen) <= IT_DEPTH);
   assign it_ok     = len_ok & ~((bus.ITCond == 4'b1110) & (|(~bus.ITMask & len_mask)));
   assign it_try    = bus.ITStart & bus.InstrValid & ~bus.Flush;
   assign it_accept = it_try & ~in_it_q & it_ok;
   assign it_err_d  = it_try & (in_it_q | ~it_ok);

   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         flags_d[b] = flags_q[b];
         if (gate && bus.BankSel == BW'(b)) begin
            if (bus.FlagW[1]) flags_d[b][3:2] = bus.ALUFlags[3:2];
            if (bus.FlagW[0]) flags_d[b][1:0] = bus.ALUFlags[1:0];
         end
      end
   end

   always_comb begin
      in_it_d     = in_it_q;
      it_remain_d = it_remain_q;
      mask_d      = mask_q;
      it_cond_d   = it_cond_q;
      if (bus.Flush) begin
         in_it_d     = 1'b0;
         it_remain_d = '0;
         mask_d      = '0;
      end else if (it_accept) begin
         in_it_d     = 1'b1;
         it_remain_d = bus.ITLen;
         mask_d      = bus.ITMask;
         it_cond_d   = bus.ITCond;
      end else if (in_it_q && bus.InstrValid) begin
         if (bus.PCSrc) begin
            in_it_d     = 1'b0;
            it_remain_d = '0;
            mask_d      = '0;
         end else begin
            mask_d      = mask_q >> 1;
            it_remain_d = it_remain_q - LW'(1);
            if (it_remain_q == LW'(1)) in_it_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         for (int b = 0; b < NUM_BANKS; b++) flags_q[b] <= 4'b0000;
         in_it_q     <= 1'b0;
         it_remain_q <= '0;
         mask_q      <= '0;
         it_cond_q   <= 4'b0000;
         it_err_q    <= 1'b0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) flags_q[b] <= flags_d[b];
         in_it_q     <= in_it_d;
         it_remain_q <= it_remain_d;
         mask_q      <= mask_d;
         it_cond_q   <= it_cond_d;
         it_err_q    <= it_err_d;
      end
   end
endmodule

// File: tb/tb_cond_logic_it.sv
// tb/tb_cond_logic_it.sv - scoreboard bench for cond_logic_it against a slot-queue reference model
// Driver pushes per-cycle expectations; monitor pops and compares on the falling edge.
module tb_cond_logic_it;
   localparam int NB = 2;
   localparam int D  = 4;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int LW = $clog2(D + 1);

   typedef struct packed {
      logic          iv;
      logic          pcs;
      logic          regw;
      logic          memw;
      logic [1:0]    fw;
      logic [3:0]    cond;
      logic [3:0]    alu;
      logic [BW-1:0] bank;
      logic          its;
      logic [3:0]    itc;
      logic [D-1:0]  itm;
      logic [LW-1:0] itl;
      logic          fl;
   } stim_t;

   typedef struct packed {
      logic          cex;
      logic          pcsrc;
      logic          rw;
      logic          mw;
      logic [3:0]    fo;
      logic          init;
      logic [LW-1:0] rem;
      logic          err;
   } exp_t;

   logic CLK = 1'b0;
   logic RESETn = 1'b0;
   always #5 CLK = ~CLK;

   cond_logic_it_if #(.NUM_BANKS(NB), .IT_DEPTH(D)) ifc ();
   cond_logic_it #(.NUM_BANKS(NB), .IT_DEPTH(D)) dut (.CLK(CLK), .RESETn(RESETn), .bus(ifc));

   int tests = 0;
   int fails = 0;
   exp_t exp_q[$];

   logic [3:0] m_flags [NB];
   logic [3:0] m_slots[$];
   logic       m_err;

   task automatic chk(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         0:  return z;
         1:  return !z;
         2:  return cy;
         3:  return !cy;
         4:  return n;
         5:  return !n;
         6:  return v;
         7:  return !v;
         8:  return cy && !z;
         9:  return !cy || z;
         10: return n == v;
         11: return n != v;
         12: return !z && (n == v);
         13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   task automatic model_reset();
      for (int b = 0; b < NB; b++) m_flags[b] = 4'b0000;
      m_slots.delete();
      m_err = 1'b0;
   endtask

   task automatic apply(input stim_t s);
      ifc.InstrValid = s.iv;   ifc.PCS = s.pcs;     ifc.RegW = s.regw;  ifc.MemW = s.memw;
      ifc.FlagW = s.fw;        ifc.Cond = s.cond;   ifc.ALUFlags = s.alu;
      ifc.BankSel = s.bank;    ifc.ITStart = s.its; ifc.ITCond = s.itc;
      ifc.ITMask = s.itm;      ifc.ITLen = s.itl;   ifc.Flush = s.fl;
   endtask

   task automatic step(input stim_t s);
      exp_t e;
      logic in_it, cex, go, ok, else_hit;
      logic [3:0] eff, f;
      int len;
      @(posedge CLK);
      #1;
      apply(s);
      in_it = (m_slots.size() > 0);
      f = (int'(s.bank) < NB) ? m_flags[s.bank] : 4'b0000;
      eff = in_it ? m_slots[0] : s.cond;
      cex = (s.its && !in_it) ? 1'b1 : cond_holds(eff, f);
      go = s.iv && cex && !s.its;
      e.cex = cex;
      e.pcsrc = s.pcs && go;
      e.rw = s.regw && go;
      e.mw = s.memw && go;
      e.fo = f;
      e.init = in_it;
      e.rem = LW'(m_slots.size());
      e.err = m_err;
      exp_q.push_back(e);

      if (go && int'(s.bank) < NB) begin
         if (s.fw[1]) m_flags[s.bank][3:2] = s.alu[3:2];
         if (s.fw[0]) m_flags[s.bank][1:0] = s.alu[1:0];
      end
      len = int'(s.itl);
      else_hit = 1'b0;
      for (int i = 0; i < D; i++) if (i < len && !s.itm[i]) else_hit = 1'b1;
      ok = (len >= 1) && (len <= D) && !(s.itc == 4'b1110 && else_hit);
      m_err = s.iv && s.its && !s.fl && (in_it || !ok);
      if (s.fl) begin
         m_slots.delete();
      end else if (s.iv && s.its && !in_it && ok) begin
         for (int i = 0; i < len; i++)
            m_slots.push_back(s.itm[i] ? s.itc : {s.itc[3:1], ~s.itc[0]});
      end else if (in_it && s.iv) begin
         if (e.pcsrc) m_slots.delete();
         else void'(m_slots.pop_front());
      end
   endtask

   task automatic reset_pulse();
      stim_t idle;
      @(posedge CLK);
      #2;
      RESETn = 1'b0;
      #1;
      chk("async_reset_init", int'(ifc.InIT), 0);
      chk("async_reset_remain", int'(ifc.ITRemain), 0);
      #1;
      RESETn = 1'b1;
      model_reset();
      idle = '0;
      apply(idle);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("CondEx", int'(ifc.CondEx), int'(e.cex));
            chk("PCSrc", int'(ifc.PCSrc), int'(e.pcsrc));
            chk("RegWrite", int'(ifc.RegWrite), int'(e.rw));
            chk("MemWrite", int'(ifc.MemWrite), int'(e.mw));
            chk("FlagsOut", int'(ifc.FlagsOut), int'(e.fo));
            chk("InIT", int'(ifc.InIT), int'(e.init));
            chk("ITRemain", int'(ifc.ITRemain), int'(e.rem));
            chk("ITErr", int'(ifc.ITErr), int'(e.err));
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin : driver
      stim_t s;
      s = '0;
      apply(s);
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      RESETn = 1'b1;

      // reset state and EQ/AL with cleared flags
      s = '0; s.iv = 1; s.regw = 1; s.cond = 4'b0000; step(s);
      s.cond = 4'b1110; step(s);
      // bank isolation
      s = '0; s.iv = 1; s.cond = 4'b1110; s.alu = 4'b0100; s.fw = 2'b10; step(s);
      s = '0; step(s);
      s = '0; s.iv = 1; s.regw = 1; s.cond = 4'b0000; s.bank = 1; step(s);

      // full table sweep; second instruction tries to overwrite all flags
      for (int f = 0; f < 16; f++) begin
         for (int c = 0; c < 16; c++) begin
            s = '0; s.iv = 1; s.cond = 4'b1110; s.fw = 2'b11; s.alu = 4'(f); step(s);
            s = '0; s.iv = 1; s.regw = 1; s.memw = 1; s.fw = 2'b11;
            s.cond = 4'(c); s.alu = ~4'(f); step(s);
         end
      end

      // IT EQ,NE,EQ,NE with Z=1 and a mid-block stall
      s = '0; s.iv = 1; s.cond = 4'b1110; s.fw = 2'b11; s.alu = 4'b0100; step(s);
      s = '0; s.iv = 1; s.its = 1; s.itc = 4'b0000; s.itm = 4'b0101; s.itl = 4; step(s);
      s = '0; s.iv = 1; s.regw = 1; s.cond = 4'b0001;
      step(s); step(s);
      s.iv = 0; step(s);
      s.iv = 1; step(s); step(s);
      s = '0; step(s);

      // rejections
      s = '0; s.iv = 1; s.its = 1; s.itc = 4'b0000; s.itm = 4'b1111; s.itl = 0; step(s);
      s = '0; step(s);
      s = '0; s.iv = 1; s.its = 1; s.itc = 4'b1110; s.itm = 4'b1110; s.itl = 1; step(s);
      s = '0; step(s);
      s = '0; s.iv = 1; s.its = 1; s.itc = 4'b1110; s.itm = 4'b1111; s.itl = 4; step(s);
      s = '0; s.iv = 1; s.regw = 1; step(s);
      s = '0; s.iv = 1; s.its = 1; s.itc = 4'b0001; s.itm = 4'b0000; s.itl = 2; s.regw = 1; step(s);
      s = '0; s.iv = 1; s.regw = 1; step(s); step(s);
      s = '0; step(s);

      // flush with IT start, then taken branch in slot 2
      s = '0; s.iv = 1; s.its = 1; s.fl = 1; s.itc = 4'b0000; s.itm = 4'b1111; s.itl = 3; step(s);
      s = '0; step(s);
      s = '0; s.iv = 1; s.its = 1; s.itc = 4'b1110; s.itm = 4'b1111; s.itl = 4; step(s);
      s = '0; s.iv = 1; s.regw = 1; step(s);
      s.pcs = 1; step(s);
      s = '0; step(s);

      // asynchronous reset mid-block
      s = '0; s.iv = 1; s.its = 1; s.itc = 4'b0000; s.itm = 4'b1010; s.itl = 4; step(s);
      s = '0; s.iv = 1; s.regw = 1; step(s);
      reset_pulse();
      s = '0; step(s);

      // randomized traffic
      for (int k = 0; k < 2000; k++) begin
         s = '0;
         s.iv   = ($urandom_range(0, 3) != 0);
         s.pcs  = ($urandom_range(0, 7) == 0);
         s.regw = 1'($urandom);
         s.memw = 1'($urandom);
         s.fw   = 2'($urandom);
         s.cond = 4'($urandom);
         s.alu  = 4'($urandom);
         s.bank = BW'($urandom_range(0, NB - 1));
         s.its  = ($urandom_range(0, 5) == 0);
         s.itc  = ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom);
         s.itm  = D'($urandom);
         s.itl  = LW'($urandom);
         s.fl   = ($urandom_range(0, 19) == 0);
         step(s);
      end

      @(negedge CLK);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
